// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg
// Shared architectural constants for the CP0 register file: register bus type,
// CP0 register numbers, reset constants for Status/Config/PrId, the Cause
// software-writable bit mask, and a helper that assembles the visible Cause word.
package cp0_reg_pkg;

    localparam int REG_W = 32;

    typedef logic [REG_W-1:0] reg_bus_t;

    localparam reg_bus_t ZERO_WORD     = '0;
    localparam logic     WRITE_ENABLE  = 1'b1;
    localparam logic     WRITE_DISABLE = 1'b0;

    // CP0 register numbers served by this block
    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    // Reset / fixed values
    localparam reg_bus_t STATUS_RESET = 32'h1000_0000;  // CU0 = 1
    localparam reg_bus_t CONFIG_RESET = 32'h0000_8000;  // BE = 1
    localparam reg_bus_t PRID_RESET   = 32'h0048_0102;

    // Cause bits software may write: IV(23), WP(22), IP[1:0](9:8)
    localparam reg_bus_t CAUSE_WR_MASK = 32'h00C0_0300;

    // Hardware interrupt pending field IP[7:2] lives at Cause[15:10]
    localparam int CAUSE_IP_HW_LSB = 10;
    localparam int CAUSE_IP_HW_W   = 6;

    // Visible Cause word: masked software bits merged with the sampled IP[7:2].
    function automatic reg_bus_t cause_view(input reg_bus_t sw_bits,
                                            input logic [CAUSE_IP_HW_W-1:0] ip_hw);
        reg_bus_t hw_bits;
        hw_bits = ZERO_WORD;
        hw_bits[CAUSE_IP_HW_LSB +: CAUSE_IP_HW_W] = ip_hw;
        return (sw_bits & CAUSE_WR_MASK) | hw_bits;
    endfunction

endpackage

// File: rtl/cp0_reg.sv
// cp0_reg
// Coprocessor-0 register file for the five-stage core. Accepts the write-back
// stage's CP0 write, serves a combinational read to the execute stage, runs the
// Count/Compare timer and samples the external interrupt lines into Cause.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   we_i         write enable from write-back
//   waddr_i      CP0 register number to write
//   data_i       write data
//   raddr_i      CP0 register number read by execute
//   int_i        level-sensitive hardware interrupt lines (int_i[5] = timer at top)
//   data_o       combinational read data for raddr_i (0 for unmapped)
//   count_o ... prid_o  direct views of each register
//   timer_int_o  sticky timer interrupt, cleared by a Compare write
module cp0_reg
    import cp0_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    reg_bus_t                   count;
    reg_bus_t                   compare;
    reg_bus_t                   status;
    reg_bus_t                   cause_sw;
    logic [CAUSE_IP_HW_W-1:0]   cause_ip_hw;
    reg_bus_t                   epc;
    logic                       timer_int;
    logic                       timer_match;

    // Compare = 0 is the "timer disabled" encoding and never raises the interrupt.
    assign timer_match = (compare != ZERO_WORD) && (count == compare);

    // All CP0 state. Later assignments in the write case override the per-cycle
    // defaults: a Count write suppresses the increment and a Compare write
    // clears the timer even when a match happens in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= ZERO_WORD;
            compare     <= ZERO_WORD;
            status      <= STATUS_RESET;
            cause_sw    <= ZERO_WORD;
            cause_ip_hw <= '0;
            epc         <= ZERO_WORD;
            timer_int   <= 1'b0;
        end else begin
            count       <= count + 32'd1;
            cause_ip_hw <= int_i;
            if (timer_match) begin
                timer_int <= 1'b1;
            end
            if (we_i == WRITE_ENABLE) begin
                case (waddr_i)
                    CP0_REG_COUNT: begin
                        count <= data_i;
                    end
                    CP0_REG_COMPARE: begin
                        compare   <= data_i;
                        timer_int <= 1'b0;
                    end
                    CP0_REG_STATUS: begin
                        status <= data_i;
                    end
                    CP0_REG_CAUSE: begin
                        cause_sw <= data_i & CAUSE_WR_MASK;
                    end
                    CP0_REG_EPC: begin
                        epc <= data_i;
                    end
                    default: begin
                        // PrId, Config and unmapped numbers ignore writes
                    end
                endcase
            end
        end
    end

    // Direct register views
    assign count_o     = count;
    assign compare_o   = compare;
    assign status_o    = status;
    assign cause_o     = cause_view(cause_sw, cause_ip_hw);
    assign epc_o       = epc;
    assign config_o    = CONFIG_RESET;
    assign prid_o      = PRID_RESET;
    assign timer_int_o = timer_int;

    // Read mux over stored state only; no bypass of a same-cycle write since
    // the execute stage forwards in-flight CP0 writes itself.
    always_comb begin
        data_o = ZERO_WORD;
        case (raddr_i)
            CP0_REG_COUNT:   data_o = count;
            CP0_REG_COMPARE: data_o = compare;
            CP0_REG_STATUS:  data_o = status;
            CP0_REG_CAUSE:   data_o = cause_view(cause_sw, cause_ip_hw);
            CP0_REG_EPC:     data_o = epc;
            CP0_REG_PRID:    data_o = PRID_RESET;
            CP0_REG_CONFIG:  data_o = CONFIG_RESET;
            default:         data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg
// Self-checking bench for cp0_reg. A stimulus process drives one cycle at a
// time and pushes the expected outputs for that cycle into a queue; a monitor
// on the falling edge pops and compares against the DUT.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    int checks = 0;
    int errors = 0;

    cp0_reg dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .raddr_i     (raddr_i),
        .int_i       (int_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .config_o    (config_o),
        .prid_o      (prid_o),
        .timer_int_o (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct {
        logic [31:0] data;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] cfg;
        logic [31:0] prid;
        logic        timer;
    } exp_t;

    exp_t expQ[$];

    // Reference model: architectural register contents
    logic [31:0] mCount, mCompare, mStatus, mCauseSw, mEpc;
    logic [5:0]  mIp;
    logic        mTimer;

    function automatic logic [31:0] modelCause();
        return (mCauseSw & 32'h00C0_0300) | (32'(mIp) << 10);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] regs [32];
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[9]  = mCount;
        regs[11] = mCompare;
        regs[12] = mStatus;
        regs[13] = modelCause();
        regs[14] = mEpc;
        regs[15] = 32'h0048_0102;
        regs[16] = 32'h0000_8000;
        return regs[a];
    endfunction

    task automatic modelReset();
        mCount   = 32'h0;
        mCompare = 32'h0;
        mStatus  = 32'h1000_0000;
        mCauseSw = 32'h0;
        mEpc     = 32'h0;
        mIp      = 6'h0;
        mTimer   = 1'b0;
    endtask

    // One clock edge of architectural behaviour, all from pre-edge values
    task automatic modelEdge(input logic weV, input logic [4:0] wa,
                             input logic [31:0] d, input logic [5:0] iv);
        logic [31:0] nCount, nCompare, nStatus, nCauseSw, nEpc;
        logic        nTimer;
        nCount   = mCount + 32'd1;
        nCompare = mCompare;
        nStatus  = mStatus;
        nCauseSw = mCauseSw;
        nEpc     = mEpc;
        nTimer   = mTimer || (mCompare != 0 && mCount == mCompare);
        if (weV) begin
            if (wa == 5'd9)  nCount = d;
            if (wa == 5'd11) begin nCompare = d; nTimer = 1'b0; end
            if (wa == 5'd12) nStatus = d;
            if (wa == 5'd13) nCauseSw = d & 32'h00C0_0300;
            if (wa == 5'd14) nEpc = d;
        end
        mCount   = nCount;
        mCompare = nCompare;
        mStatus  = nStatus;
        mCauseSw = nCauseSw;
        mEpc     = nEpc;
        mIp      = iv;
        mTimer   = nTimer;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic applyStimulus(input logic r, input logic weV, input logic [4:0] wa,
                                 input logic [31:0] d, input logic [4:0] ra,
                                 input logic [5:0] iv);
        exp_t e;
        rst     = r;
        we_i    = weV;
        waddr_i = wa;
        data_i  = d;
        raddr_i = ra;
        int_i   = iv;
        if (r) modelReset();
        e.data    = modelRead(ra);
        e.count   = mCount;
        e.compare = mCompare;
        e.status  = mStatus;
        e.cause   = modelCause();
        e.epc     = mEpc;
        e.cfg     = 32'h0000_8000;
        e.prid    = 32'h0048_0102;
        e.timer   = mTimer;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (r) modelReset();
        else   modelEdge(weV, wa, d, iv);
    endtask

    task automatic idle(input int n, input logic [4:0] ra, input logic [5:0] iv);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, ra, iv);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every cycle's outputs on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("data_o",    data_o,    e.data);
            checkOutput("count_o",   count_o,   e.count);
            checkOutput("compare_o", compare_o, e.compare);
            checkOutput("status_o",  status_o,  e.status);
            checkOutput("cause_o",   cause_o,   e.cause);
            checkOutput("epc_o",     epc_o,     e.epc);
            checkOutput("config_o",  config_o,  e.cfg);
            checkOutput("prid_o",    prid_o,    e.prid);
            checkOutput("timer_int", 32'(timer_int_o), 32'(e.timer));
        end
    end

    initial begin
        logic [4:0] addrPick [8];
        logic [4:0] wa;
        addrPick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; data_i = '0; raddr_i = '0; int_i = '0;
        modelReset();
        @(posedge clk);
        #1;
        $display("[TB] reset and count wrap");
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFE, 5'd9, 6'h0);
        idle(4, 5'd9, 6'h0);

        $display("[TB] timer match and clear");
        applyStimulus(1'b0, 1'b1, 5'd11, 32'h20, 5'd11, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h1E, 5'd9, 6'h0);
        idle(6, 5'd9, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd11, 32'h40, 5'd11, 6'h0);
        idle(2, 5'd9, 6'h0);
        // Compare write landing on the matching cycle
        applyStimulus(1'b0, 1'b1, 5'd11, 32'h60, 5'd11, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h5E, 5'd9, 6'h0);
        idle(2, 5'd9, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd11, 32'h70, 5'd9, 6'h0);
        idle(3, 5'd9, 6'h0);

        $display("[TB] cause masking");
        applyStimulus(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'h0);
        idle(1, 5'd13, 6'b101010);
        idle(2, 5'd13, 6'b101010);

        $display("[TB] read-only and unmapped");
        applyStimulus(1'b0, 1'b1, 5'd15, 32'hDEAD_BEEF, 5'd15, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd16, 32'hDEAD_BEEF, 5'd16, 6'h0);
        applyStimulus(1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 5'd3,  6'h0);
        idle(1, 5'd3, 6'h0);

        $display("[TB] read during write");
        applyStimulus(1'b0, 1'b1, 5'd14, 32'h8000_0180, 5'd14, 6'h0);
        idle(1, 5'd14, 6'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addrPick[$urandom_range(0, 7)];
            applyStimulus(1'b0, 1'($urandom_range(0, 2) == 0), wa, $urandom,
                          5'($urandom), 6'($urandom));
        end

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b1, 5'd11, mCount + 32'd3, 5'd13, 6'h3F);
        idle(4, 5'd12, 6'h15);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 6'h2A);
        applyStimulus(1'b1, 1'b1, 5'd12, 32'h1234_5678, 5'd12, 6'h2A);
        idle(3, 5'd13, 6'h11);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file for the five-stage core. Consumes the write-back stage's CP0 write (`wb_cp0_reg_we`, `wb_cp0_reg_write_addr`, `wb_cp0_reg_data`) and serves combinational reads to the execute stage. Also hosts the Count/Compare timer and samples the external interrupt lines. Its timer interrupt output is wired back into `int_i[5]` at the top level.

## Interface
- No parameters. Architectural constants come from the shared defines.
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- we_i  in  1  write enable (from wb_cp0_reg_we)
- waddr_i  in  5  write register number (from wb_cp0_reg_write_addr)
- data_i  in  32  write data (from wb_cp0_reg_data)
- raddr_i  in  5  read register number (from execute stage)
- int_i  in  6  external hardware interrupt lines, level-sensitive
- data_o  out  32  combinational read data for raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  direct register views
- timer_int_o  out  1  timer interrupt, sticky

## Operation
- Mapped registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14, PrId=15, Config=16. Writes to any other address are ignored.
- Reset values, applied asynchronously while rst=1:
  - Count: 0
  - Compare: 0
  - Status: 0x1000_0000 (CU0=1)
  - Cause: 0
  - EPC: 0
  - Config: 0x0000_8000 (BE=1)
  - PrId: 0x0048_0102
  - timer_int_o: 0
- Count:
  - increments by 1 every cycle; 32-bit modulo, 0xFFFF_FFFF wraps to 0.
  - A write loads data_i that cycle, with no increment applied.
- Compare:
  - A write loads data_i and clears timer_int_o.
- Timer:
  - Each cycle, if Compare != 0 and current Count == Compare, set timer_int_o on the next edge.
  - It stays set until a Compare write.
  - A Compare write in the same cycle as a match: the clear wins.
  - Compare=0 never fires.
- Status: all 32 bits writable.
- Cause:
  - Software-writable bits are IP[1:0] (bits 9:8), WP (bit 22) and IV (bit 23). Other bits of data_i are discarded.
  - IP[7:2] (bits 15:10) are loaded from int_i every cycle, a one-cycle registered sample, and are not software-writable.
  - All remaining bits read 0.
- EPC: all 32 bits writable.
- PrId, Config: read-only; writes ignored.
- Read path:
  - data_o is a purely combinational mux of stored state on raddr_i; unmapped addresses return 0.
  - There is no write-to-read bypass. Execute-stage forwarding covers in-flight writes from the mem and wb stages.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

## Timing
- Write latency:
  - A write presented in cycle N is visible on data_o and the direct views after the edge ending cycle N.
  - A same-cycle read returns the old value.
- Count observed at cycle N+k after a write of V at N: V+k-1 (wraps mod 2^32).
- Timer latency:
  - Count==Compare in cycle N gives timer_int_o=1 from cycle N+1.
  - A Compare write at cycle M gives timer_int_o=0 from M+1.
- Cause IP[7:2] lags int_i by exactly one cycle.
- No stall input: CP0 state advances every cycle. The write-back stage guarantees we_i is deasserted during bubbles.

## Structure
- Shared defines file holds:
  - CP0 register numbers (CP0_REG_COUNT … CP0_REG_CONFIG)
  - reset constants for Status, Config and PrId
  - `RegBus`, `ZeroWord`, `WriteEnable`/`WriteDisable`
  - the Cause writable-bit mask
- Single module, no sub-module. The timer is a few lines inside the main always block.
- Sequential block: async-reset always block on posedge clk or posedge rst. Read mux: separate combinational always.

## Test plan
- Reset values: assert rst mid-run.
  - All direct views equal the reset values immediately, with no clock edge needed.
  - timer_int_o=0.
- Count write and wrap:
  - Write Count=0xFFFF_FFFE.
  - data_o on raddr=9 reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on successive cycles.
- Timer match:
  - Write Compare=0x20, then Count=0x1E.
  - timer_int_o rises one cycle after Count reads 0x20 and stays high.
  - Writing Compare=0x40 drops it next cycle.
  - Second test: a Compare write coinciding with a match leaves timer_int_o=0.
- Cause masking:
  - Write Cause=0xFFFF_FFFF with int_i=0.
  - Cause reads 0x00C0_0300.
  - Then drive int_i=6'b101010; next cycle Cause reads 0x00C0_AB00.
- Read-only and unmapped:
  - Write 0xDEAD_BEEF to PrId, Config and address 3.
  - PrId=0x0048_0102, Config=0x0000_8000, raddr=3 returns 0.
- Read-during-write:
  - Write EPC=0x8000_0180 with raddr_i=14 in the same cycle.
  - data_o shows the old value (0) that cycle and 0x8000_0180 the next.
